// File: rtl/truth_table_sequencer.sv
// Walks every input combination onto a combinational block, captures its output per row and
// compares the captured table against an expected table.
module truth_table_sequencer #(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   expected,
  input  logic                   y_in,
  output logic [N_IN-1:0]        abc_out,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   captured,
  output logic                   pass,
  output logic [N_IN:0]          mismatch_count,
  output logic                   fail_valid,
  output logic [N_IN-1:0]        first_fail_idx
);

  localparam int unsigned Rows = 1 << N_IN;
  localparam int unsigned PhW  = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [PhW-1:0]  PhLast  = PhW'(SETTLE);
  localparam logic [N_IN-1:0] IdxLast = N_IN'(Rows - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [N_IN-1:0] idx_q;
  logic [PhW-1:0]  phase_q;
  logic            row_bad;
  logic [N_IN:0]   mm_next;

  assign row_bad = y_in ^ expected[idx_q];
  assign mm_next = mismatch_count + (N_IN + 1)'(row_bad);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      phase_q        <= '0;
      abc_out        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      captured       <= '0;
      pass           <= 1'b0;
      mismatch_count <= '0;
      fail_valid     <= 1'b0;
      first_fail_idx <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q        <= StRun;
            idx_q          <= '0;
            phase_q        <= '0;
            abc_out        <= '0;
            busy           <= 1'b1;
            captured       <= '0;
            pass           <= 1'b0;
            mismatch_count <= '0;
            fail_valid     <= 1'b0;
            first_fail_idx <= '0;
          end
        end
        StRun: begin
          if (phase_q != PhLast) begin
            phase_q <= phase_q + PhW'(1);
          end else begin
            captured[idx_q] <= y_in;
            mismatch_count  <= mm_next;
            if (row_bad && !fail_valid) begin
              first_fail_idx <= idx_q;
              fail_valid     <= 1'b1;
            end
            if (idx_q == IdxLast) begin
              state_q <= StDone;
              busy    <= 1'b0;
              done    <= 1'b1;
              abc_out <= '0;
              // Uses the post-update count so the final row's compare is included.
              pass    <= (mm_next == '0);
            end else begin
              idx_q   <= idx_q + N_IN'(1);
              phase_q <= '0;
              abc_out <= idx_q + N_IN'(1);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: one instance with SETTLE=1 and one with SETTLE=0, driven by a
// behavioural truth-table model, a vector table, hand-written corner sequences and random runs.
module tb_truth_table_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start1, start0;
  logic [7:0] exp1, exp0;
  logic       y1, y0;
  bit         use_mux;
  logic [7:0] tt;

  logic [2:0] abc1, abc0, ffi1, ffi0;
  logic       busy1, busy0, done1, done0, pass1, pass0, fv1, fv0;
  logic [7:0] cap1, cap0;
  logic [3:0] mm1, mm0;

  truth_table_sequencer #(.N_IN(3), .SETTLE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .expected(exp1), .y_in(y1),
    .abc_out(abc1), .busy(busy1), .done(done1), .captured(cap1), .pass(pass1),
    .mismatch_count(mm1), .fail_valid(fv1), .first_fail_idx(ffi1)
  );

  truth_table_sequencer #(.N_IN(3), .SETTLE(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .expected(exp0), .y_in(y0),
    .abc_out(abc0), .busy(busy0), .done(done0), .captured(cap0), .pass(pass0),
    .mismatch_count(mm0), .fail_valid(fv0), .first_fail_idx(ffi0)
  );

  // Block under test: either y = A ? C : B, or an arbitrary table t indexed by the combination.
  function automatic logic ref_y(input logic [2:0] k, input bit mux, input logic [7:0] t);
    logic a, b, c;
    a = k[2];
    b = k[1];
    c = k[0];
    if (mux) return a ? c : b;
    return t[k];
  endfunction

  always_comb y1 = ref_y(abc1, use_mux, tt);
  always_comb y0 = ref_y(abc0, use_mux, tt);

  bit         sel0;
  logic [2:0] s_abc, s_ffi;
  logic       s_busy, s_done, s_pass, s_fv;
  logic [7:0] s_cap;
  logic [3:0] s_mm;

  always_comb begin
    if (sel0) begin
      s_abc = abc0; s_ffi = ffi0; s_busy = busy0; s_done = done0;
      s_pass = pass0; s_fv = fv0; s_cap = cap0; s_mm = mm0;
    end else begin
      s_abc = abc1; s_ffi = ffi1; s_busy = busy1; s_done = done1;
      s_pass = pass1; s_fv = fv1; s_cap = cap1; s_mm = mm1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input bit v);
    if (sel0) start0 = v;
    else start1 = v;
  endtask

  task automatic run_check(input logic [7:0] t, input logic [7:0] e, input bit mux,
                           input int settle, input bit restart, input logic [7:0] xcap,
                           input int xmm, input int xff, input bit xps);
    int c;
    int seq_bad;
    int extra;
    int rowlen;
    tt      = t;
    use_mux = mux;
    exp1    = e;
    exp0    = e;
    sel0    = (settle == 0);
    rowlen  = settle + 1;
    set_start(1'b1);
    tick();
    set_start(1'b0);
    c       = 0;
    seq_bad = 0;
    while (!s_done && c < 400) begin
      if (int'(s_abc) != (c / rowlen) % 8 || !s_busy) seq_bad++;
      if (restart && c == 5) set_start(1'b1);
      tick();
      set_start(1'b0);
      c++;
    end
    chk("latency", 32'(c), 32'(8 * rowlen));
    chk("abc_seq", 32'(seq_bad), 32'(0));
    chk("captured", 32'(s_cap), 32'(xcap));
    chk("mismatch_count", 32'(s_mm), 32'(xmm));
    chk("fail_valid", 32'(s_fv), 32'(xmm != 0));
    if (xmm != 0) chk("first_fail_idx", 32'(s_ffi), 32'(xff));
    chk("pass", 32'(s_pass), 32'(xps));
    chk("done_state", 32'({s_busy, s_abc}), 32'(0));
    // start raised during DONE must not launch a new run
    set_start(1'b1);
    tick();
    set_start(1'b0);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      if (s_done || s_busy) extra++;
      tick();
    end
    chk("quiet_after_done", 32'(extra), 32'(0));
    chk("held_captured", 32'(s_cap), 32'(xcap));
    chk("held_pass", 32'(s_pass), 32'(xps));
  endtask

  typedef struct {
    logic [7:0] t;
    logic [7:0] e;
    bit         mux;
    int         settle;
    logic [7:0] cap;
    int         mm;
    int         ff;
    bit         ps;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [7:0] t, e, cap;
    int         mm, ff, settle;
    int         found;

    vecs[0] = '{8'hAC, 8'hAC, 1'b1, 1, 8'hAC, 0, 0, 1'b1};
    vecs[1] = '{8'h00, 8'hAD, 1'b1, 1, 8'hAC, 1, 0, 1'b0};
    vecs[2] = '{8'h00, 8'h53, 1'b1, 1, 8'hAC, 8, 0, 1'b0};
    vecs[3] = '{8'h00, 8'h2C, 1'b1, 0, 8'hAC, 1, 7, 1'b0};
    vecs[4] = '{8'hFF, 8'h0F, 1'b0, 1, 8'hFF, 4, 4, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 0, 8'h00, 0, 0, 1'b1};
    vecs[6] = '{8'h5A, 8'h1A, 1'b0, 1, 8'h5A, 1, 6, 1'b0};

    reset = 1'b1; start1 = 1'b1; start0 = 1'b1;
    exp1 = 8'hAC; exp0 = 8'hAC; use_mux = 1'b1; tt = 8'h00; sel0 = 1'b0;
    tick();
    tick();
    chk("reset_dut1", 32'({abc1, busy1, done1, cap1, pass1, mm1, fv1, ffi1}), 32'(0));
    chk("reset_dut0", 32'({abc0, busy0, done0, cap0, pass0, mm0, fv0, ffi0}), 32'(0));
    reset = 1'b0; start1 = 1'b0; start0 = 1'b0;
    tick();
    chk("idle_after_reset", 32'({busy1, busy0, done1, done0}), 32'(0));

    foreach (vecs[i])
      run_check(vecs[i].t, vecs[i].e, vecs[i].mux, vecs[i].settle, 1'b0, vecs[i].cap,
                vecs[i].mm, vecs[i].ff, vecs[i].ps);

    // start re-pulsed while busy, both settle values
    run_check(8'h00, 8'hAC, 1'b1, 1, 1'b1, 8'hAC, 0, 0, 1'b1);
    run_check(8'h00, 8'hAD, 1'b1, 0, 1'b1, 8'hAC, 1, 0, 1'b0);

    // reset mid-run at combination 3, after a failing run left results behind
    run_check(8'h00, 8'h53, 1'b1, 1, 1'b0, 8'hAC, 8, 0, 1'b0);
    sel0 = 1'b0; use_mux = 1'b1; exp1 = 8'hAC;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      if (abc1 == 3'd3) found = 1;
      else tick();
    end
    chk("reach_abc3", 32'(found), 32'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrun_reset", 32'({abc1, busy1, done1, cap1, pass1, mm1, fv1, ffi1}), 32'(0));
    tick();
    chk("midrun_idle", 32'({busy1, done1}), 32'(0));
    run_check(8'h00, 8'hAC, 1'b1, 1, 1'b0, 8'hAC, 0, 0, 1'b1);

    // random tables against a row-by-row reference model
    for (int r = 0; r < 24; r++) begin
      t      = 8'($urandom);
      e      = (r % 3 == 0) ? t : t ^ 8'($urandom & $urandom);
      settle = int'($urandom_range(0, 1));
      cap    = '0;
      mm     = 0;
      ff     = -1;
      for (int k = 0; k < 8; k++) begin
        cap[k] = ref_y(3'(k), 1'b0, t);
        if (cap[k] != e[k]) begin
          mm++;
          if (ff < 0) ff = k;
        end
      end
      run_check(t, e, 1'b0, settle, r[0], cap, mm, ff, mm == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
